// File: rtl/matraptor_row_dispatcher_if.sv
// Partial-product stream bus between the upstream source, the row dispatcher and the PE array.
// The dispatcher connects through the slave modport; the source/PE side uses master.
interface matraptor_row_dispatcher_if #(
  parameter int DATA_W  = 32,
  parameter int IDX_W   = 16,
  parameter int NUM_PES = 4
);
  logic               in_valid;
  logic               in_ready;
  logic [DATA_W-1:0]  in_val;
  logic [IDX_W-1:0]   in_row;
  logic [IDX_W-1:0]   in_col;
  logic               in_last;
  logic [NUM_PES-1:0] pe_valid;
  logic [NUM_PES-1:0] pe_ready;
  logic [DATA_W-1:0]  pe_val;
  logic [IDX_W-1:0]   pe_row;
  logic [IDX_W-1:0]   pe_col;
  logic               pe_last;
  logic [NUM_PES-1:0] pe_row_done;

  modport slave (
    input  in_valid, in_val, in_row, in_col, in_last, pe_ready, pe_row_done,
    output in_ready, pe_valid, pe_val, pe_row, pe_col, pe_last
  );

  modport master (
    output in_valid, in_val, in_row, in_col, in_last, pe_ready, pe_row_done,
    input  in_ready, pe_valid, pe_val, pe_row, pe_col, pe_last
  );
endinterface

// File: rtl/matraptor_row_dispatcher.sv
// Row-granular scheduler: binds each output row to one free PE (round-robin) and
// forwards only that row's beats to it, so a row is never split across PEs.
//   state  | meaning
//   IDLE   | waiting for the first beat of a stream
//   BIND   | picking a free PE for the row of the presented beat
//   STREAM | forwarding beats of cur_row to cur_pe
//   DRAIN  | last beat sent, waiting for every PE to go idle
//   DONE   | one-cycle all_done pulse
module matraptor_row_dispatcher #(
  parameter int DATA_W  = 32,
  parameter int IDX_W   = 16,
  parameter int NUM_PES = 4,
  parameter int CNT_W   = 16,
  localparam int PE_W   = (NUM_PES > 1) ? $clog2(NUM_PES) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  matraptor_row_dispatcher_if.slave  bus,
  output logic [NUM_PES-1:0]         pe_busy_o,
  output logic [PE_W-1:0]            cur_pe_o,
  output logic [CNT_W-1:0]           rows_dispatched_o,
  output logic                       all_done_o
);
  typedef enum logic [2:0] {S_IDLE, S_BIND, S_STREAM, S_DRAIN, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [NUM_PES-1:0] busy_q, busy_d;
  logic [PE_W-1:0]    rr_q, rr_d;
  logic [PE_W-1:0]    cur_pe_q, cur_pe_d;
  logic [IDX_W-1:0]   cur_row_q, cur_row_d;
  logic [CNT_W-1:0]   rows_q, rows_d;

  logic               found;
  logic [PE_W-1:0]    pick, pick_nxt, cand;
  logic               match, ready_c;
  logic [NUM_PES-1:0] pv_c;
  logic [DATA_W-1:0]  val_w;

  assign val_w       = bus.in_val;
  assign bus.pe_val  = val_w;
  assign bus.pe_row  = bus.in_row;
  assign bus.pe_col  = bus.in_col;
  assign bus.pe_last = bus.in_last;
  assign bus.in_ready = ready_c;
  assign bus.pe_valid = pv_c;

  // First non-busy PE at or after rr_q, wrapping modulo NUM_PES.
  always_comb begin
    int j;
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    j     = 0;
    for (int i = 0; i < NUM_PES; i++) begin
      j = int'(rr_q) + i;
      if (j >= NUM_PES) j = j - NUM_PES;
      cand = PE_W'(j);
      if (!found && !busy_q[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  assign pick_nxt = (int'(pick) == NUM_PES - 1) ? '0 : pick + PE_W'(1);
  assign match    = (bus.in_row == cur_row_q);

  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q & ~bus.pe_row_done;
    rr_d      = rr_q;
    cur_pe_d  = cur_pe_q;
    cur_row_d = cur_row_q;
    rows_d    = rows_q;
    ready_c   = 1'b0;
    pv_c      = '0;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          state_d = S_BIND;
          rows_d  = '0;
        end
      end
      S_BIND: begin
        if (found) begin
          cur_pe_d     = pick;
          busy_d[pick] = 1'b1;
          cur_row_d    = bus.in_row;
          rr_d         = pick_nxt;
          if (rows_q != '1) rows_d = rows_q + CNT_W'(1);
          state_d      = S_STREAM;
        end
      end
      S_STREAM: begin
        // Binding lives in cur_pe/cur_row, so an early done pulse does not stop the row.
        if (match) begin
          ready_c        = bus.pe_ready[cur_pe_q];
          pv_c[cur_pe_q] = bus.in_valid;
        end
        if (bus.in_valid && ready_c && bus.in_last) state_d = S_DRAIN;
        else if (bus.in_valid && !match)            state_d = S_BIND;
      end
      S_DRAIN: begin
        if (busy_q == '0) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      busy_q    <= '0;
      rr_q      <= '0;
      cur_pe_q  <= '0;
      cur_row_q <= '0;
      rows_q    <= '0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      rr_q      <= rr_d;
      cur_pe_q  <= cur_pe_d;
      cur_row_q <= cur_row_d;
      rows_q    <= rows_d;
    end
  end

  assign pe_busy_o         = busy_q;
  assign cur_pe_o          = cur_pe_q;
  assign rows_dispatched_o = rows_q;
  assign all_done_o        = (state_q == S_DONE);
endmodule

// File: doc/matraptor_row_dispatcher.md
Name: matraptor_row_dispatcher

Overview:
- Row-granular scheduler in front of the MatRaptor PE array.
- Accepts the flat partial-product stream (val/row/col/last), binds each output row to one free PE in round-robin order, and forwards that row's beats to the bound PE only.
- Tracks per-PE busy status from the PEs' row_done pulses, and signals stream completion once the last beat has been forwarded and every PE has gone idle.
- Replaces the column-mod demux with row ownership, so a row is never split across PEs.

Parameters:
- DATA_W, 32, partial-product value width.
- IDX_W, 16, row/column index width.
- NUM_PES, 4, number of PEs (1..16).
- PE_W, clog2(NUM_PES) (minimum 1), width of a PE index; derived, not overridable.
- CNT_W, 16, width of the rows_dispatched counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  upstream beat accepted.
- in_val  in  DATA_W  beat value.
- in_row  in  IDX_W  beat row index.
- in_col  in  IDX_W  beat column index.
- in_last  in  1  final beat of the whole stream.
- pe_valid  out  NUM_PES  one-hot valid to the bound PE.
- pe_ready  in  NUM_PES  per-PE ready.
- pe_val  out  DATA_W  broadcast data: in_val passthrough.
- pe_row  out  IDX_W  broadcast data: in_row passthrough.
- pe_col  out  IDX_W  broadcast data: in_col passthrough.
- pe_last  out  1  broadcast data: in_last passthrough.
- pe_row_done  in  NUM_PES  1-cycle pulse; PE has finished its row.
- pe_busy  out  NUM_PES  registered busy flags.
- cur_pe  out  PE_W  currently bound PE.
- rows_dispatched  out  CNT_W  rows bound since the last stream start.
- all_done  out  1  1-cycle completion pulse.

Behaviour:
- Reset: rst_n is asynchronous and active-low; clock is clk. Reset applies at any point, including mid-stream, and yields:
  - state=IDLE; pe_busy=0; rr_ptr=0; cur_pe=0; cur_row=0; rows_dispatched=0; all_done=0.
  - Combinationally, in_ready=0 and pe_valid=0 while in IDLE.
  - PEs are reset by the same rst_n.
- Datapath: pe_val/pe_row/pe_col/pe_last are zero-latency combinational copies of the in_* inputs. The handshake is combinational in both directions.
- IDLE:
  - in_ready=0.
  - On in_valid: go to BIND and clear rows_dispatched to 0.
- BIND:
  - in_ready=0 and pe_valid=0.
  - Scan p = rr_ptr, rr_ptr+1, ... (mod NUM_PES); take the first p with pe_busy[p]=0.
  - If a PE is found, on the same edge: cur_pe=p; pe_busy[p]=1; cur_row=in_row; rr_ptr=(p+1) mod NUM_PES; rows_dispatched+=1 (saturates at all-ones); go to STREAM.
  - If no PE is free: stay in BIND; nothing changes.
  - Minimum bind cost is 1 bubble cycle per row.
- STREAM:
  - match = (in_row == cur_row).
  - pe_valid[cur_pe] = in_valid & match; all other bits 0.
  - in_ready = match & pe_ready[cur_pe].
  - A beat transfers when in_valid & in_ready.
  - Transferred beat with in_last=1: go to DRAIN.
  - in_valid & !match: go to BIND; no beat is consumed, and the beat is re-presented after binding.
  - in_valid=0: hold.
  - pe_ready low: stall with in_ready=0. Upstream must hold its data stable.
- DRAIN:
  - in_ready=0.
  - When pe_busy == 0: go to DONE.
- DONE:
  - all_done=1 for exactly one cycle; go to IDLE.
  - rows_dispatched holds its value until the next stream start.
- Busy clearing:
  - pe_row_done[p] clears pe_busy[p] in any state.
  - A pulse on a non-busy PE is ignored.
  - Set and clear on the same PE in the same cycle: set wins. This is only possible for a stale pulse.
  - A done pulse for cur_pe during STREAM clears its busy flag; streaming to cur_pe continues, because the binding is held in cur_pe/cur_row, not in pe_busy.
- Boundary cases:
  - NUM_PES=1: each new row waits in BIND until the previous row's done pulse.
  - in_last on a beat whose row differs from cur_row: BIND, then stream that single beat, then DRAIN.
  - A repeated row index after a different row is treated as a new row and gets a new binding.
  - rr_ptr wraps from NUM_PES-1 to 0.

Test Plan:
- Basic binding, NUM_PES=4, all pe_ready=1, no done pulses:
  - Stimulus: rows 5,5,7,9 (last on the 9 beat).
  - Bindings 5->PE0, 7->PE1, 9->PE2.
  - pe_valid sequence 0001,0001,0010,0100, with one bubble before each row.
  - DRAIN then holds until all 3 done pulses arrive; all_done pulses once; rows_dispatched=3.
- Full array, NUM_PES=2:
  - Stimulus: rows 1,2,3 with no done pulses.
  - Dispatcher sits in BIND on row 3 with in_ready=0.
  - Pulse pe_row_done[0]: row 3 binds to PE0 on the next edge.
- Round-robin skip, NUM_PES=4:
  - Setup: pe_busy=1011, rr_ptr=1.
  - New row binds to PE2, and rr_ptr becomes 3.
- Backpressure:
  - Stimulus: pe_ready[0]=0 for 3 cycles mid-row 4.
  - in_ready=0 and pe_valid[0]=1 throughout the stall; no beat is lost or duplicated; beat count at PE0 equals the input count.
- Spurious and simultaneous events:
  - A done pulse to idle PE3 leaves pe_busy unchanged.
  - Assert rst_n=0 mid-STREAM: next cycle all outputs are at their reset values, and the following stream starts binding at PE0.
